// File: rtl/mem_port_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;
    typedef enum logic [1:0] {GNT_NONE, GNT_IF, GNT_D} gnt_e;

    localparam logic [3:0] FETCH_BE = 4'hF;

endpackage

// File: rtl/mem_port_arb_fair_ctr.sv
// Saturating count of fetch deferrals; force_if asserts once fetch has lost MAX_DEFER times in a row.
module mem_port_arb_fair_ctr #(
    parameter int MAX_DEFER = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic defer,
    input  logic clr,
    output logic force_if
);

    localparam int W = $clog2(MAX_DEFER + 1);
    localparam logic [W-1:0] MAX_V = W'(MAX_DEFER);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (defer && cnt_q != MAX_V)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign force_if = (cnt_q == MAX_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and data access; data has priority.
// Define MEM_PORT_ARB_FAIRNESS_EN to enable the fetch starvation guard.
module mem_port_arbiter
    import mem_port_arb_pkg::*;
#(
    parameter int MAX_DEFER = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem
);

    state_e      state_q, state_d;
    gnt_e        gnt;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        d_ready_q, d_ready_d;
    logic        if_pend, d_pend, force_if;

    // A requester whose ready pulse is out this cycle is still holding req; don't reissue it.
    assign if_pend = if_req & ~if_ready_q;
    assign d_pend  = d_req & ~d_ready_q;

`ifdef MEM_PORT_ARB_FAIRNESS_EN
    mem_port_arb_fair_ctr #(.MAX_DEFER(MAX_DEFER)) u_fair_ctr (
        .clk      (clk),
        .rst      (rst),
        .defer    ((gnt == GNT_D) && if_pend),
        .clr      (gnt == GNT_IF),
        .force_if (force_if)
    );
`else
    localparam int unused_max_defer = MAX_DEFER;
    assign force_if = 1'b0;
`endif

    always_comb begin
        gnt = GNT_NONE;
        if (state_q == IDLE) begin
            if (d_pend && !(if_pend && force_if)) gnt = GNT_D;
            else if (if_pend)                     gnt = GNT_IF;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ready_d  = 1'b0;
        d_ready_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt == GNT_D) begin
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end else if (gnt == GNT_IF) begin
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = FETCH_BE;
                end
            end
            BUSY_IF: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_ready_d = 1'b1;
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    if (!mem_we_q) d_rdata_d = mem_rdata;
                    d_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ready_q  <= if_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector table for mem_port_arbiter plus starvation and mid-transaction reset sequences.
module tb_mem_port_arbiter;

    localparam logic [31:0] IA = 32'h1000_0000;
    localparam logic [31:0] IB = 32'h1000_0004;
    localparam logic [31:0] DA = 32'h2000_0004;
    localparam logic [31:0] DS = 32'h2000_0008;
    localparam logic [31:0] AR = 32'hA5A5_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, d_req, d_we, mem_ack;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_ready, d_ready, mem_req, mem_we, stall_if, stall_mem;
    logic [3:0]  mem_be;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MAX_DEFER(3)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic [3:0]  d_be;
        logic        ack;
        logic [31:0] rdata;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic [3:0]  x_be;
        logic        x_ifr;
        logic        x_dr;
        logic [31:0] x_ifrd;
        logic [31:0] x_drd;
        logic        x_sif;
        logic        x_smem;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd, input logic [3:0] dbe,
                       input logic ak, input logic [31:0] rd,
                       input logic xr, input logic xw, input logic [31:0] xa, input logic [31:0] xwd,
                       input logic [3:0] xbe, input logic xifr, input logic xdr,
                       input logic [31:0] xifrd, input logic [31:0] xdrd, input logic xsif, input logic xsm);
        vec_t v;
        v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dw;  v.d_addr = da;
        v.d_wdata = dwd; v.d_be = dbe;   v.ack = ak;    v.rdata = rd;
        v.x_req = xr;   v.x_we = xw;     v.x_addr = xa; v.x_wdata = xwd; v.x_be = xbe;
        v.x_ifr = xifr; v.x_dr = xdr;    v.x_ifrd = xifrd; v.x_drd = xdrd;
        v.x_sif = xsif; v.x_smem = xsm;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
        d_wdata = '0; d_be = '0; mem_ack = 0; mem_rdata = '0;
    endtask

    initial begin
        logic fair_build;
        logic exp_fetch;
`ifdef MEM_PORT_ARB_FAIRNESS_EN
        fair_build = 1'b1;
`else
        fair_build = 1'b0;
`endif
        // Each row is one cycle: inputs driven in it, outputs expected during it.
        // Lone fetch, ack one cycle after grant.
        add(1, IA, 0, 0, 0, 0, 0,      0, 0,          0, 0, 0,  0, 0,       0, 0, 0,      0,  1, 0);
        add(1, IA, 0, 0, 0, 0, 0,      1, 32'h13,     1, 0, IA, 0, 4'hF,    0, 0, 0,      0,  1, 0);
        add(1, IA, 0, 0, 0, 0, 0,      0, 0,          0, 0, 0,  0, 0,       1, 0, 32'h13, 0,  0, 0);
        add(0, 0,  0, 0, 0, 0, 0,      0, 0,          0, 0, 0,  0, 0,       0, 0, 32'h13, 0,  0, 0);
        // Collision: data load first, fetch granted in the d_ready cycle, 3-cycle acks.
        add(1, IB, 1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0,  0, 0, 0,  0, 0,          0, 0, 32'h13, 0,  1, 1);
        add(1, IB, 1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0,  1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0, 32'h13, 0,  1, 1);
        add(1, IB, 1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0,  1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0, 32'h13, 0,  1, 1);
        add(1, IB, 1, 0, DA, 32'hCAFE0000, 4'hF, 1, AR, 1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0, 32'h13, 0,  1, 1);
        add(1, IB, 1, 0, DA, 32'hCAFE0000, 4'hF, 0, 0,  0, 0, 0,  0, 0,          0, 1, 32'h13, AR, 1, 0);
        add(1, IB, 0, 0, 0, 0, 0,      0, 0,          1, 0, IB, 0, 4'hF,    0, 0, 32'h13, AR, 1, 0);
        add(1, IB, 0, 0, 0, 0, 0,      0, 0,          1, 0, IB, 0, 4'hF,    0, 0, 32'h13, AR, 1, 0);
        add(1, IB, 0, 0, 0, 0, 0,      1, 32'h93,     1, 0, IB, 0, 4'hF,    0, 0, 32'h13, AR, 1, 0);
        add(1, IB, 0, 0, 0, 0, 0,      0, 0,          0, 0, 0,  0, 0,       1, 0, 32'h93, AR, 0, 0);
        add(0, 0,  0, 0, 0, 0, 0,      0, 0,          0, 0, 0,  0, 0,       0, 0, 32'h93, AR, 0, 0);
        // Store; address/data changes after grant must not reach the bus; d_rdata keeps its value.
        add(0, 0, 1, 1, DS, 32'hDEADBEEF, 4'b0011, 0, 0,  0, 0, 0, 0, 0,  0, 0, 32'h93, AR, 0, 1);
        add(0, 0, 1, 1, 32'h2000000C, 32'h11111111, 4'hF, 0, 0,
            1, 1, DS, 32'hDEADBEEF, 4'b0011, 0, 0, 32'h93, AR, 0, 1);
        add(0, 0, 1, 1, 32'h2000000C, 32'h11111111, 4'hF, 1, 32'hFFFFFFFF,
            1, 1, DS, 32'hDEADBEEF, 4'b0011, 0, 0, 32'h93, AR, 0, 1);
        add(0, 0, 1, 1, DS, 32'hDEADBEEF, 4'b0011, 0, 0,  0, 0, 0, 0, 0,  0, 1, 32'h93, AR, 0, 0);
        // Stray ack while idle is ignored.
        add(0, 0, 0, 0, 0, 0, 0,       1, 32'h12345678, 0, 0, 0, 0, 0,  0, 0, 32'h93, AR, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,       0, 0,            0, 0, 0, 0, 0,  0, 0, 32'h93, AR, 0, 0);

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset.mem_req", {31'b0, mem_req}, 0);
        chk("reset.mem_we", {31'b0, mem_we}, 0);
        chk("reset.if_ready", {31'b0, if_ready}, 0);
        chk("reset.d_ready", {31'b0, d_ready}, 0);
        chk("reset.mem_addr", mem_addr, 0);
        chk("reset.mem_wdata", mem_wdata, 0);
        chk("reset.mem_be", {28'b0, mem_be}, 0);
        chk("reset.rdata", if_rdata | d_rdata, 0);
        @(posedge clk); #1 rst = 1'b0;

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            d_req = vecs[i].d_req;   d_we = vecs[i].d_we;   d_addr = vecs[i].d_addr;
            d_wdata = vecs[i].d_wdata; d_be = vecs[i].d_be;
            mem_ack = vecs[i].ack;   mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("r%0d.mem_req", i), {31'b0, mem_req}, {31'b0, vecs[i].x_req});
            chk($sformatf("r%0d.mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].x_we});
            chk($sformatf("r%0d.if_ready", i), {31'b0, if_ready}, {31'b0, vecs[i].x_ifr});
            chk($sformatf("r%0d.d_ready", i), {31'b0, d_ready}, {31'b0, vecs[i].x_dr});
            chk($sformatf("r%0d.if_rdata", i), if_rdata, vecs[i].x_ifrd);
            chk($sformatf("r%0d.d_rdata", i), d_rdata, vecs[i].x_drd);
            chk($sformatf("r%0d.stall_if", i), {31'b0, stall_if}, {31'b0, vecs[i].x_sif});
            chk($sformatf("r%0d.stall_mem", i), {31'b0, stall_mem}, {31'b0, vecs[i].x_smem});
            if (vecs[i].x_req) begin
                chk($sformatf("r%0d.mem_addr", i), mem_addr, vecs[i].x_addr);
                chk($sformatf("r%0d.mem_wdata", i), mem_wdata, vecs[i].x_wdata);
                chk($sformatf("r%0d.mem_be", i), {28'b0, mem_be}, {28'b0, vecs[i].x_be});
            end
        end

        // Starvation: both requesters collide each round; fetch withdraws after losing so the
        // d_ready cycle does not hand it the port. The fourth collision goes to fetch only in the
        // fairness build; the fifth shows the counter was cleared by that fetch grant.
        for (int r = 0; r < 5; r++) begin
            exp_fetch = fair_build && (r == 3);
            @(posedge clk); #1;
            idle_inputs();
            if_req = 1; if_addr = IA; d_req = 1; d_addr = DA; d_be = 4'hF;
            @(posedge clk); #1;
            if_req = 0; d_req = 0; mem_ack = 1; mem_rdata = 32'h100 + r;
            @(negedge clk);
            chk($sformatf("starve%0d.mem_req", r), {31'b0, mem_req}, 1);
            chk($sformatf("starve%0d.grant_addr", r), mem_addr, exp_fetch ? IA : DA);
            @(posedge clk); #1 mem_ack = 0;
            @(negedge clk);
            chk($sformatf("starve%0d.if_ready", r), {31'b0, if_ready}, {31'b0, exp_fetch});
            chk($sformatf("starve%0d.d_ready", r), {31'b0, d_ready}, {31'b0, ~exp_fetch});
            chk($sformatf("starve%0d.rdata", r), exp_fetch ? if_rdata : d_rdata, 32'h100 + r);
        end

        // Reset while a store is on the bus.
        @(posedge clk); #1;
        idle_inputs();
        d_req = 1; d_we = 1; d_addr = DS; d_wdata = 32'h55; d_be = 4'hF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstmid.pre_req", {31'b0, mem_req}, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.async_req", {31'b0, mem_req}, 0);
        chk("rstmid.async_we", {31'b0, mem_we}, 0);
        d_req = 0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid.no_ready0", {31'b0, d_ready}, 0);
        @(posedge clk); #1 mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("rstmid.req_after", {31'b0, mem_req}, 0);
        @(posedge clk); #1 mem_ack = 0;
        @(negedge clk);
        chk("rstmid.no_ready1", {31'b0, d_ready}, 0);
        chk("rstmid.d_rdata", d_rdata, 0);
        chk("rstmid.mem_req", {31'b0, mem_req}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
